// File: rtl/aes_wddl_pkg.sv
// Shared types and helpers for the WDDL AES round datapath.
// Column c of a 128-bit state occupies bits [127-32c -: 32], with sa0 in the top byte.
package aes_wddl_pkg;

  localparam int COL_W   = 32;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } mc_state_e;

  function automatic logic [COL_W-1:0] col_sel(input logic [STATE_W-1:0] s, input logic [1:0] c);
    return s[STATE_W-1-COL_W*int'(c) -: COL_W];
  endfunction

endpackage

// File: rtl/aes_mixcol_seq_wddl_if.sv
// Dual-rail 128-bit state stream with valid/ready handshake.
// The producer uses master, the consumer uses slave.
interface aes_mixcol_seq_wddl_if;
  import aes_wddl_pkg::*;

  logic               valid;
  logic               ready;
  logic               last;
  logic [STATE_W-1:0] state_p;
  logic [STATE_W-1:0] state_n;

  modport master (output valid, last, state_p, state_n, input ready);
  modport slave  (input valid, last, state_p, state_n, output ready);
endinterface

// File: rtl/aes_wddl_drchk.sv
// Combinational dual-rail codeword checker.
// It flags any bit position where the true and false rails are equal.
module aes_wddl_drchk
  import aes_wddl_pkg::*;
(
  input  logic [COL_W-1:0] p,
  input  logic [COL_W-1:0] n,
  output logic             err
);
  assign err = |(p ~^ n);
endmodule

// File: rtl/aes_mixcol_seq_wddl.sv
// Feeds one dual-rail state through a shared WDDL MixColumns unit, one column at a time,
// and inserts a precharge before every evaluation. Each captured column is checked as a dual-rail codeword.
module aes_mixcol_seq_wddl
  import aes_wddl_pkg::*;
#(
  parameter int PRE_CYCLES = 1,
  parameter bit CONST_TIME = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_mixcol_seq_wddl_if.slave  in_if,
  aes_mixcol_seq_wddl_if.master out_if,
  output logic [COL_W-1:0]      mc_col_p,
  output logic [COL_W-1:0]      mc_col_n,
  input  logic [COL_W-1:0]      mc_res_p,
  input  logic [COL_W-1:0]      mc_res_n,
  output logic                  dr_err,
  output logic                  busy
);

  localparam logic [1:0] PRE_LAST = 2'(PRE_CYCLES - 1);

  mc_state_e          state_q, state_d;
  logic [1:0]         col_q, col_d, pcnt_q, pcnt_d;
  logic               last_q, last_d, dr_err_q, dr_err_d;
  logic [STATE_W-1:0] in_p_q, in_p_d, in_n_q, in_n_d;
  logic [STATE_W-1:0] out_p_q, out_p_d, out_n_q, out_n_d;
  logic [COL_W-1:0]   mc_col_p_q, mc_col_p_d, mc_col_n_q, mc_col_n_d;
  logic [COL_W-1:0]   res_p, res_n;
  logic               res_err;
  logic [3:0]         in_err;
  logic               xfer;

  // A last-round column is passed through unchanged.
  assign res_p = last_q ? mc_col_p_q : mc_res_p;
  assign res_n = last_q ? mc_col_n_q : mc_res_n;

  aes_wddl_drchk u_chk_res (.p(res_p), .n(res_n), .err(res_err));

  for (genvar c = 0; c < 4; c++) begin : g_in_chk
    aes_wddl_drchk u_chk_in (
      .p   (in_if.state_p[STATE_W-1-COL_W*c -: COL_W]),
      .n   (in_if.state_n[STATE_W-1-COL_W*c -: COL_W]),
      .err (in_err[c])
    );
  end

  assign xfer = in_if.valid && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    pcnt_d   = pcnt_q;
    last_d   = last_q;
    dr_err_d = dr_err_q;
    in_p_d   = in_p_q;
    in_n_d   = in_n_q;
    out_p_d  = out_p_q;
    out_n_d  = out_n_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          in_p_d = in_if.state_p;
          in_n_d = in_if.state_n;
          last_d = in_if.last;
          col_d  = 2'd0;
          pcnt_d = 2'd0;
          if (!CONST_TIME && in_if.last) begin
            state_d = DONE;
            out_p_d = in_if.state_p;
            out_n_d = in_if.state_n;
            if (|in_err) dr_err_d = 1'b1;
          end else begin
            state_d = PRE;
          end
        end
      end
      PRE: begin
        if (pcnt_q == PRE_LAST) state_d = EVAL;
        else                    pcnt_d  = pcnt_q + 2'd1;
      end
      EVAL: begin
        out_p_d[STATE_W-1-COL_W*int'(col_q) -: COL_W] = res_p;
        out_n_d[STATE_W-1-COL_W*int'(col_q) -: COL_W] = res_n;
        if (res_err) dr_err_d = 1'b1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end else begin
          col_d   = col_q + 2'd1;
          pcnt_d  = 2'd0;
          state_d = PRE;
        end
      end
      DONE: begin
        if (out_if.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so the shared unit only ever sees clean precharge/evaluate transitions.
    mc_col_p_d = (state_d == EVAL) ? col_sel(in_p_q, col_d) : '0;
    mc_col_n_d = (state_d == EVAL) ? col_sel(in_n_q, col_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= 2'd0;
      pcnt_q     <= 2'd0;
      last_q     <= 1'b0;
      dr_err_q   <= 1'b0;
      in_p_q     <= '0;
      in_n_q     <= '0;
      out_p_q    <= '0;
      out_n_q    <= '0;
      mc_col_p_q <= '0;
      mc_col_n_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      pcnt_q     <= pcnt_d;
      last_q     <= last_d;
      dr_err_q   <= dr_err_d;
      in_p_q     <= in_p_d;
      in_n_q     <= in_n_d;
      out_p_q    <= out_p_d;
      out_n_q    <= out_n_d;
      mc_col_p_q <= mc_col_p_d;
      mc_col_n_q <= mc_col_n_d;
    end
  end

  assign in_if.ready    = (state_q == IDLE);
  assign out_if.valid   = (state_q == DONE);
  assign out_if.last    = last_q;
  assign out_if.state_p = out_p_q;
  assign out_if.state_n = out_n_q;
  assign mc_col_p       = mc_col_p_q;
  assign mc_col_n       = mc_col_n_q;
  assign dr_err         = dr_err_q;
  assign busy           = (state_q != IDLE);

endmodule
